// File: rtl/laser_arbiter.sv
// Round-robin arbiter sharing one laser emitter among N_REQ requesters.
// Each grant fires the laser for PULSE_LEN cycles, followed by COOLDOWN idle cycles.
module laser_arbiter #(
   parameter int N_REQ     = 4,
   parameter int PULSE_LEN = 3,
   parameter int COOLDOWN  = 2,
   parameter int CW        = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic                       abort,
   output logic [N_REQ-1:0]           ack,
   output logic                       x,
   output logic [$clog2(N_REQ)-1:0]   owner,
   output logic                       busy,
   output logic                       done
);

   localparam int OW = $clog2(N_REQ);
   localparam logic [CW-1:0] PL_M1 = CW'(PULSE_LEN - 1);
   localparam logic [CW-1:0] CD_M1 = (COOLDOWN > 0) ? CW'(COOLDOWN - 1) : '0;
   localparam bit HAS_COOL = (COOLDOWN > 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FIRE = 2'd1,
      S_COOL = 2'd2
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [CW-1:0]     r_cnt, w_cnt_nxt;
   logic [OW-1:0]     r_last, w_last_nxt;
   logic [OW-1:0]     r_owner, w_owner_nxt;
   logic [N_REQ-1:0]  r_ack, w_ack_nxt;
   logic              r_x, w_x_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_done, w_done_nxt;

   logic              w_gnt_found;
   logic [OW-1:0]     w_gnt_idx;
   logic [OW-1:0]     w_cand;
   logic              w_pulse_end;

   // Scan upward from the slot after the last grantee, wrapping modulo N_REQ.
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      w_cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_cand = OW'((int'(r_last) + k) % N_REQ);
         if (!w_gnt_found && req[w_cand]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = w_cand;
         end
      end
   end

   assign w_pulse_end = abort || (r_cnt == '0);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_last_nxt  = r_last;
      w_owner_nxt = r_owner;
      w_ack_nxt   = '0;
      w_x_nxt     = 1'b0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_gnt_found) begin
               w_ack_nxt[w_gnt_idx] = 1'b1;
               w_owner_nxt = w_gnt_idx;
               w_last_nxt  = w_gnt_idx;
               w_cnt_nxt   = PL_M1;
               w_state_nxt = S_FIRE;
               w_x_nxt     = 1'b1;
               w_busy_nxt  = 1'b1;
            end
         end
         S_FIRE: begin
            if (w_pulse_end) begin
               // An aborted pulse still pays the full cooldown but never reports done.
               w_done_nxt = !abort;
               if (HAS_COOL) begin
                  w_state_nxt = S_COOL;
                  w_cnt_nxt   = CD_M1;
                  w_busy_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_cnt_nxt  = r_cnt - CW'(1);
               w_x_nxt    = 1'b1;
               w_busy_nxt = 1'b1;
            end
         end
         S_COOL: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt  = r_cnt - CW'(1);
               w_busy_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_owner_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_last  <= OW'(N_REQ - 1);
         r_owner <= '0;
         r_ack   <= '0;
         r_x     <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         r_owner <= w_owner_nxt;
         r_ack   <= w_ack_nxt;
         r_x     <= w_x_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
      r_cnt <= w_cnt_nxt;
   end

   assign ack   = r_ack;
   assign x     = r_x;
   assign owner = r_owner;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule
